debug_commit_tracker: RTL and testbench
=======================================

Name: debug_commit_tracker

Overview:
- Sits directly upstream of the simulation Debug/DPI block, between the CPU writeback/commit point and that block.
- Registers one retire record per committed instruction and classifies device (MMIO) accesses against the main-memory window.
- Detects ebreak and stuck-pipeline timeouts and raises a single halt record.
- Drives the exact debug_* record the Debug block consumes, plus a retired-instruction counter.

Parameters:
- MEM_BASE, 32'h8000_0000, base of the main-memory window.
- MEM_SIZE, 32'h0800_0000, size of the main-memory window in bytes.
- TIMEOUT, 1_000_000, idle cycles with no commit before a forced halt; must be ≥ 2, held in a 32-bit counter.
- EBREAK_INST, 32'h0010_0073, instruction word that requests a halt.

Ports:
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- cmt_valid  in  1  one instruction retires this cycle
- cmt_pc  in  32  PC of the retiring instruction
- cmt_inst  in  32  instruction word
- cmt_regWen  in  1  GPR write enable
- cmt_regWaddr  in  5  GPR destination
- cmt_regWdata  in  32  GPR write data
- cmt_memValid  in  1  instruction performed a load/store
- cmt_memAddr  in  32  load/store byte address
- debug_valid  out  1  record valid (one-cycle pulse per record)
- debug_halt  out  1  record ends simulation
- debug_deviceAccess  out  1  access fell outside the memory window
- debug_deviceAddr  out  32  device address, 0 when not a device access
- debug_pc  out  32  record PC
- debug_regWen  out  1  record GPR write enable
- debug_regWaddr  out  5  record GPR destination
- debug_regWdata  out  32  record GPR write data
- instret  out  64  count of accepted commits
- timeout  out  1  sticky; halt was caused by the watchdog

Behaviour:
- Reset (reset==0, asynchronous):
  - All outputs 0; instret 0; watchdog counter 0; last_pc 0; state RUN.
  - Reset asserted mid-record drops that record. There is no partial output.
- All debug_* outputs are registered, so each record appears exactly 1 cycle after its cmt_* inputs. No backpressure exists; every accepted commit produces exactly one record.
- States: RUN, HALTED. There is no transition out of HALTED except reset.
- RUN, cmt_valid=1 (accepted commit):
  - debug_valid=1 next cycle; pc, inst-derived and reg fields copied.
  - debug_regWen = cmt_regWen && (cmt_regWaddr != 0). Waddr and wdata pass through unchanged.
  - Device test uses 33-bit unsigned arithmetic, so MEM_BASE+MEM_SIZE does not wrap: in_mem = (addr >= MEM_BASE) && (addr < MEM_BASE+MEM_SIZE).
  - debug_deviceAccess = cmt_memValid && !in_mem.
  - debug_deviceAddr = cmt_memAddr if deviceAccess, else 0.
  - instret += 1 (64-bit, wraps silently). last_pc <= cmt_pc. Watchdog counter <= 0.
  - If cmt_inst == EBREAK_INST: the same record carries debug_halt=1 and state -> HALTED. The ebreak is counted in instret.
- RUN, cmt_valid=0:
  - Watchdog counter increments.
  - When counter == TIMEOUT-1 in a cycle with no commit, next cycle emits a synthetic record: debug_valid=1, debug_halt=1, debug_pc=last_pc, regWen=0, regWaddr=0, regWdata=0, deviceAccess=0, deviceAddr=0.
  - In that case timeout <= 1 (sticky) and state -> HALTED. instret is unchanged.
- Simultaneous commit and watchdog expiry in the same cycle: the commit wins, the counter clears, and no timeout occurs.
- HALTED:
  - cmt_* are ignored; debug_valid=0 and debug_halt=0, so the halt is a single pulse.
  - instret and timeout hold; the counter is frozen.
- Every non-record cycle drives debug_valid=0 and debug_halt=0. Data fields may hold their last values; the bench checks them only when valid=1.

Decomposition:
- Shared package debug_pkg holds:
  - EBREAK_INST constant.
  - Default MEM_BASE and MEM_SIZE.
  - State enum {RUN, HALTED}.
  - Packed struct debug_rec_t {valid, halt, deviceAccess, deviceAddr, pc, regWen, regWaddr, regWdata}. The same struct is reusable by the Debug block's bench monitor.
- One sub-module, debug_watchdog: counter, clear input, enable input, expire pulse, parameter TIMEOUT. The top block owns state, classification and output registers.

Test Plan:
- Commit pc=0x80000000, regWen=1, waddr=5, wdata=0xDEAD, no mem -> next cycle valid=1, regWen=1, waddr=5, deviceAccess=0; instret=1.
- Commit with regWen=1, waddr=0 -> record with regWen=0. Store to 0xA0000048 -> deviceAccess=1, deviceAddr=0xA0000048. Store to 0x87FFFFFC -> deviceAccess=0, deviceAddr=0. Store to 0x88000000 -> deviceAccess=1.
- Commit inst=0x00100073 at pc=0x80000010, followed by further commits -> one record with halt=1, pc=0x80000010. No further valid. instret counts the ebreak.
- TIMEOUT=8: commit pc=0x80000020, then 8 idle cycles -> synthetic record valid=1, halt=1, pc=0x80000020, regWen=0; timeout=1; later commits ignored.
- TIMEOUT=8: 7 idle cycles, then a commit in the expiry cycle -> normal record with halt=0 and timeout stays 0. Then 8 more idle cycles -> timeout halt fires.
- Drive reset low mid-run (async, off clock edge) -> all outputs 0 immediately. After release, state RUN, instret=0, and a subsequent ebreak halts again.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the commit tracker and anything that consumes its
// debug_* record (for example a bench monitor on the Debug block side).
//   EBREAK_INST            : instruction word that requests a halt
//   DEF_MEM_BASE/SIZE      : default main-memory window
//   state_e                : tracker run state
//   debug_rec_t            : one retire/halt record as seen by the Debug block
//   addr_in_window()       : 33-bit window test, immune to base+size wrap
package debug_pkg;

    localparam logic [31:0] EBREAK_INST  = 32'h0010_0073;
    localparam logic [31:0] DEF_MEM_BASE = 32'h8000_0000;
    localparam logic [31:0] DEF_MEM_SIZE = 32'h0800_0000;

    typedef enum logic {
        RUN,
        HALTED
    } state_e;

    typedef struct packed {
        logic        valid;
        logic        halt;
        logic        deviceAccess;
        logic [31:0] deviceAddr;
        logic [31:0] pc;
        logic        regWen;
        logic [4:0]  regWaddr;
        logic [31:0] regWdata;
    } debug_rec_t;

    // Extending to 33 bits keeps base+size from wrapping for windows that
    // end at the top of the 32-bit address space.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] size);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = {1'b0, base} + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/debug_watchdog.sv
// Idle-cycle watchdog for the commit tracker.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : a commit happened this cycle; restart the count
//   enable_i      : count only while enabled (frozen otherwise)
//   expire_o      : combinational pulse in the cycle where the count reaches
//                   TIMEOUT-1 without a commit; the caller registers the halt
module debug_watchdog #(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [31:0] LAST = 32'(TIMEOUT - 1);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // A commit in the expiry cycle wins, so clear masks the pulse.
    assign expire_o = enable_i && !clear_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (enable_i) begin
            if (clear_i) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debug_commit_tracker.sv
// Registers one debug record per retired instruction for the Debug/DPI block,
// classifies loads/stores outside the main-memory window as device accesses,
// and emits a single halt record on ebreak or on a stuck-pipeline timeout.
//   clock, reset       : clock, asynchronous active-low reset
//   cmt_*              : commit-point retire information (one per cycle max)
//   debug_*            : registered record, valid one cycle after its commit
//   instret            : 64-bit count of accepted commits
//   timeout            : sticky, set when the watchdog caused the halt
module debug_commit_tracker #(
    parameter logic [31:0] MEM_BASE    = debug_pkg::DEF_MEM_BASE,
    parameter logic [31:0] MEM_SIZE    = debug_pkg::DEF_MEM_SIZE,
    parameter int unsigned TIMEOUT     = 1_000_000,
    parameter logic [31:0] EBREAK_INST = debug_pkg::EBREAK_INST
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmt_valid,
    input  logic [31:0] cmt_pc,
    input  logic [31:0] cmt_inst,
    input  logic        cmt_regWen,
    input  logic [4:0]  cmt_regWaddr,
    input  logic [31:0] cmt_regWdata,
    input  logic        cmt_memValid,
    input  logic [31:0] cmt_memAddr,
    output logic        debug_valid,
    output logic        debug_halt,
    output logic        debug_deviceAccess,
    output logic [31:0] debug_deviceAddr,
    output logic [31:0] debug_pc,
    output logic        debug_regWen,
    output logic [4:0]  debug_regWaddr,
    output logic [31:0] debug_regWdata,
    output logic [63:0] instret,
    output logic        timeout
);

    import debug_pkg::*;

    state_e      state_q;
    debug_rec_t  rec_q;
    debug_rec_t  commit_rec_d;
    debug_rec_t  timeout_rec_d;
    logic [63:0] instret_q;
    logic        timeout_q;
    logic [31:0] last_pc_q;
    logic        is_ebreak;
    logic        dev_access;
    logic        wd_expire;

    debug_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clock),
        .rst_ni   (reset),
        .clear_i  (cmt_valid),
        .enable_i (state_q == RUN),
        .expire_o (wd_expire)
    );

    assign is_ebreak  = (cmt_inst == EBREAK_INST);
    assign dev_access = cmt_memValid && !addr_in_window(cmt_memAddr, MEM_BASE, MEM_SIZE);

    always_comb begin
        commit_rec_d              = '0;
        commit_rec_d.valid        = 1'b1;
        commit_rec_d.halt         = is_ebreak;
        commit_rec_d.deviceAccess = dev_access;
        commit_rec_d.deviceAddr   = dev_access ? cmt_memAddr : '0;
        commit_rec_d.pc           = cmt_pc;
        commit_rec_d.regWen       = cmt_regWen && (cmt_regWaddr != 5'd0);
        commit_rec_d.regWaddr     = cmt_regWaddr;
        commit_rec_d.regWdata     = cmt_regWdata;
    end

    // Synthetic halt record: only pc survives, everything else zero.
    always_comb begin
        timeout_rec_d       = '0;
        timeout_rec_d.valid = 1'b1;
        timeout_rec_d.halt  = 1'b1;
        timeout_rec_d.pc    = last_pc_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            rec_q     <= '0;
            instret_q <= '0;
            timeout_q <= 1'b0;
            last_pc_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (cmt_valid) begin
                        rec_q     <= commit_rec_d;
                        instret_q <= instret_q + 64'd1;
                        last_pc_q <= cmt_pc;
                        if (is_ebreak) begin
                            state_q <= HALTED;
                        end
                    end else if (wd_expire) begin
                        rec_q     <= timeout_rec_d;
                        timeout_q <= 1'b1;
                        state_q   <= HALTED;
                    end else begin
                        rec_q.valid <= 1'b0;
                        rec_q.halt  <= 1'b0;
                    end
                end
                HALTED: begin
                    rec_q.valid <= 1'b0;
                    rec_q.halt  <= 1'b0;
                end
            endcase
        end
    end

    assign debug_valid        = rec_q.valid;
    assign debug_halt         = rec_q.halt;
    assign debug_deviceAccess = rec_q.deviceAccess;
    assign debug_deviceAddr   = rec_q.deviceAddr;
    assign debug_pc           = rec_q.pc;
    assign debug_regWen       = rec_q.regWen;
    assign debug_regWaddr     = rec_q.regWaddr;
    assign debug_regWdata     = rec_q.regWdata;
    assign instret            = instret_q;
    assign timeout            = timeout_q;

endmodule

// File: tb/tb_debug_commit_tracker.sv
module tb_debug_commit_tracker;

    localparam int unsigned TO = 8;
    localparam longint unsigned MB = 64'h8000_0000;
    localparam longint unsigned MS = 64'h0800_0000;
    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmt_valid = 1'b0;
    logic [31:0] cmt_pc = '0;
    logic [31:0] cmt_inst = '0;
    logic        cmt_regWen = 1'b0;
    logic [4:0]  cmt_regWaddr = '0;
    logic [31:0] cmt_regWdata = '0;
    logic        cmt_memValid = 1'b0;
    logic [31:0] cmt_memAddr = '0;
    logic        debug_valid, debug_halt, debug_deviceAccess, debug_regWen, timeout;
    logic [31:0] debug_deviceAddr, debug_pc, debug_regWdata;
    logic [4:0]  debug_regWaddr;
    logic [63:0] instret;

    int errors = 0;
    int checks = 0;

    debug_commit_tracker #(
        .MEM_BASE (32'h8000_0000),
        .MEM_SIZE (32'h0800_0000),
        .TIMEOUT  (TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .cmt_valid          (cmt_valid),
        .cmt_pc             (cmt_pc),
        .cmt_inst           (cmt_inst),
        .cmt_regWen         (cmt_regWen),
        .cmt_regWaddr       (cmt_regWaddr),
        .cmt_regWdata       (cmt_regWdata),
        .cmt_memValid       (cmt_memValid),
        .cmt_memAddr        (cmt_memAddr),
        .debug_valid        (debug_valid),
        .debug_halt         (debug_halt),
        .debug_deviceAccess (debug_deviceAccess),
        .debug_deviceAddr   (debug_deviceAddr),
        .debug_pc           (debug_pc),
        .debug_regWen       (debug_regWen),
        .debug_regWaddr     (debug_regWaddr),
        .debug_regWdata     (debug_regWdata),
        .instret            (instret),
        .timeout            (timeout)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    bit              m_halted;
    int unsigned     m_idle;
    logic [31:0]     m_last_pc;
    longint unsigned m_instret;
    bit              m_timeout;
    bit              e_valid, e_halt, e_wen, e_dev;
    logic [31:0]     e_pc, e_wd, e_devaddr;
    logic [4:0]      e_wa;

    task automatic model_reset();
        m_halted = 0; m_idle = 0; m_last_pc = '0; m_instret = 0; m_timeout = 0;
        e_valid = 0; e_halt = 0; e_wen = 0; e_dev = 0;
        e_pc = '0; e_wd = '0; e_devaddr = '0; e_wa = '0;
    endtask

    task automatic model_step();
        longint unsigned a;
        bit inm;
        if (m_halted) begin
            e_valid = 0; e_halt = 0;
        end else if (cmt_valid) begin
            a   = 64'(cmt_memAddr);
            inm = (a >= MB) && (a < MB + MS);
            e_valid   = 1;
            e_halt    = (cmt_inst == EBRK);
            e_pc      = cmt_pc;
            e_wen     = cmt_regWen && (cmt_regWaddr != 0);
            e_wa      = cmt_regWaddr;
            e_wd      = cmt_regWdata;
            e_dev     = cmt_memValid && !inm;
            e_devaddr = e_dev ? cmt_memAddr : 32'h0;
            m_instret = m_instret + 1;
            m_last_pc = cmt_pc;
            m_idle    = 0;
            if (e_halt) m_halted = 1;
        end else begin
            m_idle = m_idle + 1;
            if (m_idle == TO) begin
                e_valid = 1; e_halt = 1; e_pc = m_last_pc;
                e_wen = 0; e_wa = '0; e_wd = '0; e_dev = 0; e_devaddr = '0;
                m_timeout = 1; m_halted = 1;
            end else begin
                e_valid = 0; e_halt = 0;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 64'(debug_valid), 64'(e_valid));
        chk({tag, ".halt"}, 64'(debug_halt), 64'(e_halt));
        chk({tag, ".instret"}, instret, m_instret);
        chk({tag, ".timeout"}, 64'(timeout), 64'(m_timeout));
        if (e_valid) begin
            chk({tag, ".pc"}, 64'(debug_pc), 64'(e_pc));
            chk({tag, ".regWen"}, 64'(debug_regWen), 64'(e_wen));
            chk({tag, ".regWaddr"}, 64'(debug_regWaddr), 64'(e_wa));
            chk({tag, ".regWdata"}, 64'(debug_regWdata), 64'(e_wd));
            chk({tag, ".devAcc"}, 64'(debug_deviceAccess), 64'(e_dev));
            chk({tag, ".devAddr"}, 64'(debug_deviceAddr), 64'(e_devaddr));
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_model(tag);
    endtask

    task automatic set_idle();
        cmt_valid = 0; cmt_pc = '0; cmt_inst = '0; cmt_regWen = 0;
        cmt_regWaddr = '0; cmt_regWdata = '0; cmt_memValid = 0; cmt_memAddr = '0;
    endtask

    task automatic set_commit(input logic [31:0] pc, input logic [31:0] inst,
                              input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                              input logic mv, input logic [31:0] ma);
        cmt_valid = 1; cmt_pc = pc; cmt_inst = inst; cmt_regWen = wen;
        cmt_regWaddr = wa; cmt_regWdata = wd; cmt_memValid = mv; cmt_memAddr = ma;
    endtask

    // Called just after a posedge: asserts reset off-edge, checks outputs
    // cleared immediately, then releases off-edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 0;
        #1;
        chk({tag, ".rst_valid"}, 64'(debug_valid), 64'h0);
        chk({tag, ".rst_halt"}, 64'(debug_halt), 64'h0);
        chk({tag, ".rst_pc"}, 64'(debug_pc), 64'h0);
        chk({tag, ".rst_devAddr"}, 64'(debug_deviceAddr), 64'h0);
        chk({tag, ".rst_instret"}, instret, 64'h0);
        chk({tag, ".rst_timeout"}, 64'(timeout), 64'h0);
        model_reset();
        set_idle();
        @(posedge clock);
        #3;
        reset = 1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        mv;
        logic [31:0] ma;
        logic        x_dev;
        logic [31:0] x_devaddr;
        logic        x_wen;
    } vec_t;

    vec_t vt[$];

    initial begin
        vt.push_back('{32'h8000_0000, 1, 5'd5,  32'h0000_DEAD, 0, 32'h0,         0, 32'h0,         1});
        vt.push_back('{32'h8000_0004, 1, 5'd0,  32'h0000_1234, 0, 32'h0,         0, 32'h0,         0});
        vt.push_back('{32'h8000_0008, 0, 5'd3,  32'h0,         1, 32'hA000_0048, 1, 32'hA000_0048, 0});
        vt.push_back('{32'h8000_000C, 0, 5'd3,  32'h0,         1, 32'h87FF_FFFC, 0, 32'h0,         0});
        vt.push_back('{32'h8000_0010, 0, 5'd3,  32'h0,         1, 32'h8800_0000, 1, 32'h8800_0000, 0});
        vt.push_back('{32'h8000_0014, 1, 5'd7,  32'h5555_AAAA, 1, 32'h7FFF_FFFC, 1, 32'h7FFF_FFFC, 1});
        vt.push_back('{32'h8000_0018, 1, 5'd8,  32'h1,         1, 32'h8000_0000, 0, 32'h0,         1});
        vt.push_back('{32'h8000_001C, 0, 5'd0,  32'h0,         1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0});
        vt.push_back('{32'h8000_0020, 0, 5'd0,  32'h0,         0, 32'hA000_0000, 0, 32'h0,         0});
        vt.push_back('{32'h8000_0024, 1, 5'd31, 32'hFFFF_FFFF, 0, 32'h0,         0, 32'h0,         1});

        model_reset();
        set_idle();
        #12;
        chk("reset.valid", 64'(debug_valid), 64'h0);
        chk("reset.instret", instret, 64'h0);
        chk("reset.timeout", 64'(timeout), 64'h0);
        @(posedge clock);
        #3;
        reset = 1;

        // Table-driven commits
        foreach (vt[i]) begin
            set_commit(vt[i].pc, NOP, vt[i].wen, vt[i].wa, vt[i].wd, vt[i].mv, vt[i].ma);
            cycle($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.valid", i), 64'(debug_valid), 64'h1);
            chk($sformatf("tbl%0d.devAcc", i), 64'(debug_deviceAccess), 64'(vt[i].x_dev));
            chk($sformatf("tbl%0d.devAddr", i), 64'(debug_deviceAddr), 64'(vt[i].x_devaddr));
            chk($sformatf("tbl%0d.regWen", i), 64'(debug_regWen), 64'(vt[i].x_wen));
            chk($sformatf("tbl%0d.instret", i), instret, 64'(i + 1));
        end
        set_idle();
        cycle("tbl_idle");
        chk("tbl_idle.valid", 64'(debug_valid), 64'h0);

        // Ebreak halt
        do_reset("eb");
        set_commit(32'h8000_0000, NOP, 1, 5'd1, 32'h11, 0, 32'h0);
        cycle("eb0");
        set_commit(32'h8000_0010, EBRK, 0, 5'd0, 32'h0, 0, 32'h0);
        cycle("eb1");
        chk("eb1.halt", 64'(debug_halt), 64'h1);
        chk("eb1.pc", 64'(debug_pc), 64'h8000_0010);
        chk("eb1.instret", instret, 64'd2);
        for (int k = 0; k < 4; k++) begin
            set_commit(32'h8000_0014 + 32'(4 * k), NOP, 1, 5'd2, 32'h22, 0, 32'h0);
            cycle("eb_after");
            chk("eb_after.valid", 64'(debug_valid), 64'h0);
        end
        chk("eb_after.instret", instret, 64'd2);

        // Watchdog halt after TO idle cycles
        do_reset("wd");
        set_commit(32'h8000_0020, NOP, 1, 5'd4, 32'h44, 0, 32'h0);
        cycle("wd_c");
        set_idle();
        for (int k = 0; k < int'(TO) - 1; k++) begin
            cycle("wd_idle");
            chk("wd_idle.valid", 64'(debug_valid), 64'h0);
        end
        cycle("wd_fire");
        chk("wd_fire.valid", 64'(debug_valid), 64'h1);
        chk("wd_fire.halt", 64'(debug_halt), 64'h1);
        chk("wd_fire.pc", 64'(debug_pc), 64'h8000_0020);
        chk("wd_fire.regWen", 64'(debug_regWen), 64'h0);
        chk("wd_fire.timeout", 64'(timeout), 64'h1);
        chk("wd_fire.instret", instret, 64'd1);
        for (int k = 0; k < 3; k++) begin
            set_commit(32'h8000_0100, NOP, 1, 5'd4, 32'h44, 0, 32'h0);
            cycle("wd_after");
            chk("wd_after.valid", 64'(debug_valid), 64'h0);
            chk("wd_after.timeout", 64'(timeout), 64'h1);
        end

        // Commit lands in the expiry cycle
        do_reset("wx");
        set_idle();
        for (int k = 0; k < int'(TO) - 1; k++) cycle("wx_idle");
        set_commit(32'h8000_0040, NOP, 1, 5'd9, 32'h99, 0, 32'h0);
        cycle("wx_c");
        chk("wx_c.valid", 64'(debug_valid), 64'h1);
        chk("wx_c.halt", 64'(debug_halt), 64'h0);
        chk("wx_c.timeout", 64'(timeout), 64'h0);
        set_idle();
        for (int k = 0; k < int'(TO) - 1; k++) cycle("wx_idle2");
        cycle("wx_fire");
        chk("wx_fire.halt", 64'(debug_halt), 64'h1);
        chk("wx_fire.pc", 64'(debug_pc), 64'h8000_0040);
        chk("wx_fire.timeout", 64'(timeout), 64'h1);

        // Async reset mid-run, then ebreak halts again
        do_reset("ar");
        for (int k = 0; k < 3; k++) begin
            set_commit(32'h8000_0200 + 32'(4 * k), NOP, 1, 5'd6, 32'h66, 1, 32'hA000_0000);
            cycle("ar_c");
        end
        chk("ar_c.instret", instret, 64'd3);
        do_reset("ar_mid");
        set_commit(32'h8000_0300, EBRK, 0, 5'd0, 32'h0, 0, 32'h0);
        cycle("ar_eb");
        chk("ar_eb.halt", 64'(debug_halt), 64'h1);
        chk("ar_eb.instret", instret, 64'd1);
        set_commit(32'h8000_0304, NOP, 1, 5'd1, 32'h1, 0, 32'h0);
        cycle("ar_eb2");
        chk("ar_eb2.valid", 64'(debug_valid), 64'h0);

        // Randomized traffic against the model
        begin
            int streak;
            logic [31:0] addrs [6];
            logic [31:0] a;
            logic [31:0] inst;
            streak = 0;
            addrs[0] = 32'h7FFF_FFFC; addrs[1] = 32'h8000_0000; addrs[2] = 32'h87FF_FFFC;
            addrs[3] = 32'h8800_0000; addrs[4] = 32'hFFFF_FFFC; addrs[5] = 32'h1000_0000;
            do_reset("rnd");
            for (int n = 0; n < 3000; n++) begin
                if (m_halted && $urandom_range(0, 3) == 0) begin
                    do_reset("rnd_rst");
                end
                if (streak > 0) begin
                    set_idle();
                    streak--;
                end else if ($urandom_range(0, 9) == 0) begin
                    set_idle();
                    streak = $urandom_range(1, 10);
                end else if ($urandom_range(0, 3) == 0) begin
                    set_idle();
                end else begin
                    a = ($urandom_range(0, 1) == 0) ? addrs[$urandom_range(0, 5)] : $urandom;
                    inst = ($urandom_range(0, 39) == 0) ? EBRK : $urandom;
                    set_commit($urandom, inst, 1'($urandom), 5'($urandom), $urandom,
                               1'($urandom), a);
                end
                cycle("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "time limit");
    end

endmodule
